// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam int unsigned MAX_DIG   = 32;

  // All digit selects released (active-low); callers truncate to NUM_DIG.
  function automatic logic [MAX_DIG-1:0] dig_off();
    return '1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_dec.sv
// Hex nibble to active-low 7-segment pattern (gfedcba).
module seg_dec (
  input  logic [3:0] iHex,
  output logic [6:0] oSEG7
);

  always_comb begin
    oSEG7 = 7'h7F;
    unique case (iHex)
      4'h0: oSEG7 = 7'h40;
      4'h1: oSEG7 = 7'h79;
      4'h2: oSEG7 = 7'h24;
      4'h3: oSEG7 = 7'h30;
      4'h4: oSEG7 = 7'h19;
      4'h5: oSEG7 = 7'h12;
      4'h6: oSEG7 = 7'h02;
      4'h7: oSEG7 = 7'h78;
      4'h8: oSEG7 = 7'h00;
      4'h9: oSEG7 = 7'h10;
      4'hA: oSEG7 = 7'h08;
      4'hB: oSEG7 = 7'h03;
      4'hC: oSEG7 = 7'h46;
      4'hD: oSEG7 = 7'h21;
      4'hE: oSEG7 = 7'h06;
      4'hF: oSEG7 = 7'h0E;
      default: oSEG7 = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with blanking gap,
// frame-coherent shadow value and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG   = 4,
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iEn,
  input  logic [4*NUM_DIG-1:0]   iValue,
  input  logic                   iLoad,
  input  logic                   iLzs,
  output logic [NUM_DIG-1:0]     oDigSel,
  output logic [6:0]             oSEG7,
  output logic                   oLoadAck,
  output logic                   oFrame
);

  localparam int unsigned CW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
  localparam int unsigned IW = (clog2(NUM_DIG) > 0) ? clog2(NUM_DIG) : 1;
  localparam int unsigned VW = 4 * NUM_DIG;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [VW-1:0]        hold_q, hold_d;
  logic [VW-1:0]        shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [NUM_DIG-1:0]   dig_sel_q, dig_sel_d;
  logic [6:0]           seg_q, seg_d;
  logic                 load_ack_q, load_ack_d;
  logic                 frame_q, frame_d;

  logic                 upd_point;
  logic [3:0]           dec_hex;
  logic [6:0]           dec_seg;
  logic                 lz_sup;

  seg_dec u_seg_dec (
    .iHex  (dec_hex),
    .oSEG7 (dec_seg)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= OFF;
      idx_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      dig_sel_q  <= NUM_DIG'(dig_off());
      seg_q      <= SEG_BLANK;
      load_ack_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
      load_ack_q <= load_ack_d;
      frame_q    <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!iEn) begin
      state_d = OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow only moves at a frame boundary or while dark, so a frame never tears.
  always_comb begin
    frame_d    = (state_d == BLANK) && (idx_d == '0) && (state_q != BLANK);
    upd_point  = (state_q == OFF) || frame_d;
    hold_d     = hold_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    if (upd_point) begin
      pending_d = 1'b0;
      if (iLoad) begin
        shadow_d   = iValue;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        shadow_d   = hold_q;
        load_ack_d = 1'b1;
      end
    end else if (iLoad) begin
      hold_d    = iValue;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    dec_hex = '0;
    lz_sup  = iLzs && (idx_d != '0);
    for (int unsigned k = 0; k < NUM_DIG; k++) begin
      if (idx_d == IW'(k)) dec_hex = shadow_q[4*k +: 4];
      if ((IW'(k) >= idx_d) && (shadow_q[4*k +: 4] != 4'h0)) lz_sup = 1'b0;
    end
  end

  always_comb begin
    dig_sel_d = NUM_DIG'(dig_off());
    seg_d     = SEG_BLANK;
    if (state_d == SHOW) begin
      dig_sel_d[idx_d] = 1'b0;
      seg_d            = lz_sup ? SEG_BLANK : dec_seg;
    end
  end

  assign oDigSel  = dig_sel_q;
  assign oSEG7    = seg_q;
  assign oLoadAck = load_ack_q;
  assign oFrame   = frame_q;

endmodule
